// File: rtl/and64.sv
// and64: Y86-64 ALU logical-AND slice with a registered, valid-tagged result.
// Define AND64_FLAGS_EN to add registered ZF/SF/OF condition-code outputs.
module and64 (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        in_valid,
  output wire  [63:0] ans,
  output logic [63:0] ans_q,
  output logic        out_valid
`ifdef AND64_FLAGS_EN
  ,
  output logic        zf,
  output logic        sf,
  output logic        of
`endif
);

  for (genvar i = 0; i < 64; i++) begin : g_bit
    and u_and (ans[i], a[i], b[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ans_q     <= '0;
      out_valid <= 1'b0;
    end else if (in_valid) begin
      ans_q     <= ans;
      out_valid <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end

`ifdef AND64_FLAGS_EN
  // AND never carries or overflows, so OF is held at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      zf <= 1'b0;
      sf <= 1'b0;
      of <= 1'b0;
    end else if (in_valid) begin
      zf <= (ans == 64'd0);
      sf <= ans[63];
      of <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_and64.sv
// tb_and64: self-checking bench for and64 against a behavioural model.
// Flag checks are compiled in when AND64_FLAGS_EN is defined.
module tb_and64;

  logic        clk;
  logic        rst;
  logic [63:0] a;
  logic [63:0] b;
  logic        in_valid;
  wire  [63:0] ans;
  wire  [63:0] ans_q;
  wire         out_valid;
`ifdef AND64_FLAGS_EN
  wire         zf;
  wire         sf;
  wire         of;
`endif

  int tests = 0;
  int fails = 0;

  logic [63:0] m_q;
  logic        m_v;
  logic        m_zf;
  logic        m_sf;

  and64 dut (
    .clk(clk),
    .rst(rst),
    .a(a),
    .b(b),
    .in_valid(in_valid),
    .ans(ans),
    .ans_q(ans_q),
    .out_valid(out_valid)
`ifdef AND64_FLAGS_EN
    ,
    .zf(zf),
    .sf(sf),
    .of(of)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: per-bit AND of the sampled operands, captured on valid.
  function automatic logic [63:0] ref_and(input logic [63:0] x, input logic [63:0] y);
    logic [63:0] r;
    for (int i = 0; i < 64; i++) r[i] = x[i] && y[i];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_q = '0; m_v = 1'b0; m_zf = 1'b0; m_sf = 1'b0;
    end else if (in_valid) begin
      m_q  = ref_and(a, b);
      m_v  = 1'b1;
      m_zf = (m_q == 64'd0);
      m_sf = m_q[63];
    end else begin
      m_v = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0;
    a = {$urandom, $urandom}; b = {$urandom, $urandom};
    tick(); tick();
    tests++;
    if (ans_q !== 64'd0) begin
      fails++; $display("FAIL reset_ans_q got=%h exp=0", ans_q);
    end
    tests++;
    if (out_valid !== 1'b0) begin
      fails++; $display("FAIL reset_out_valid got=%b exp=0", out_valid);
    end
`ifdef AND64_FLAGS_EN
    tests++;
    if ({zf, sf, of} !== 3'b000) begin
      fails++; $display("FAIL reset_flags got=%b exp=000", {zf, sf, of});
    end
`endif
    rst = 1'b0;
  endtask

  task automatic test_all_ones();
    a = '1; b = '1; in_valid = 1'b1;
    #1;
    tests++;
    if (ans !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      fails++; $display("FAIL ones_ans got=%h exp=ffffffffffffffff", ans);
    end
    tick();
    in_valid = 1'b0;
    tests++;
    if (ans_q !== 64'hFFFF_FFFF_FFFF_FFFF || out_valid !== 1'b1) begin
      fails++;
      $display("FAIL ones_reg got=%h/%b exp=ffffffffffffffff/1", ans_q, out_valid);
    end
`ifdef AND64_FLAGS_EN
    tests++;
    if ({zf, sf, of} !== 3'b010) begin
      fails++; $display("FAIL ones_flags got=%b exp=010", {zf, sf, of});
    end
`endif
  endtask

  task automatic test_back_to_back();
    logic [63:0] op;
    logic [63:0] prev;
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      op = 64'hFFFF_FFFF_FFFF_FFFE - 64'(k);
      prev = ans_q;
      a = op; b = op;
      #1;
      tests++;
      if (ans !== op) begin
        fails++; $display("FAIL b2b_ans k=%0d got=%h exp=%h", k, ans, op);
      end
      if (k > 0) begin
        tests++;
        if (prev !== op + 64'd1) begin
          fails++; $display("FAIL b2b_trail k=%0d got=%h exp=%h", k, prev, op + 64'd1);
        end
      end
      tick();
      tests++;
      if (ans_q !== op || out_valid !== 1'b1) begin
        fails++;
        $display("FAIL b2b_reg k=%0d got=%h/%b exp=%h/1", k, ans_q, out_valid, op);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_patterns();
    logic [63:0] ta [5];
    logic [63:0] tb [5];
    logic [63:0] te [5];
    ta = '{64'h1, 64'hAAAA_AAAA_AAAA_AAAA, 64'hF0F0_F0F0_F0F0_F0F0, 64'h0, '1};
    tb = '{'1, 64'h5555_5555_5555_5555, 64'h0F0F_0F0F_0F0F_0F0F, '1, 64'h0};
    te = '{64'h1, 64'h0, 64'h0, 64'h0, 64'h0};
    for (int k = 0; k < 5; k++) begin
      a = ta[k]; b = tb[k]; in_valid = 1'b1;
      #1;
      tests++;
      if (ans !== te[k]) begin
        fails++; $display("FAIL pat_ans k=%0d got=%h exp=%h", k, ans, te[k]);
      end
      tick();
      in_valid = 1'b0;
      tests++;
      if (ans_q !== te[k] || out_valid !== 1'b1) begin
        fails++;
        $display("FAIL pat_reg k=%0d got=%h/%b exp=%h/1", k, ans_q, out_valid, te[k]);
      end
`ifdef AND64_FLAGS_EN
      tests++;
      if (zf !== (k != 0) || sf !== 1'b0 || of !== 1'b0) begin
        fails++;
        $display("FAIL pat_flags k=%0d got=%b exp=%b00", k, {zf, sf, of}, (k != 0));
      end
`endif
    end
  endtask

  task automatic test_reset_priority();
    a = '1; b = '1; in_valid = 1'b1;
    tick();
    a = {$urandom, $urandom} | 64'h8000_0000_0000_0001; b = '1; rst = 1'b1;
    tick();
    tests++;
    if (ans_q !== 64'd0 || out_valid !== 1'b0) begin
      fails++; $display("FAIL rstprio_reg got=%h/%b exp=0/0", ans_q, out_valid);
    end
`ifdef AND64_FLAGS_EN
    tests++;
    if ({zf, sf, of} !== 3'b000) begin
      fails++; $display("FAIL rstprio_flags got=%b exp=000", {zf, sf, of});
    end
`endif
    tests++;
    if (ans !== a) begin
      fails++; $display("FAIL rstprio_ans got=%h exp=%h", ans, a);
    end
    rst = 1'b0; in_valid = 1'b0;
    tick();
  endtask

  task automatic test_valid_drop();
    logic [63:0] held;
    a = 64'h1234_5678_9ABC_DEF0; b = 64'h0FF0_0FF0_FFFF_0000; in_valid = 1'b1;
    held = 64'h0230_0670_9ABC_0000;
    tick();
    a = '1; b = 64'h0000_0000_0000_00FF; in_valid = 1'b0;
    tick();
    tests++;
    if (out_valid !== 1'b0) begin
      fails++; $display("FAIL drop_valid got=%b exp=0", out_valid);
    end
    tests++;
    if (ans_q !== held) begin
      fails++; $display("FAIL drop_hold got=%h exp=%h", ans_q, held);
    end
    tests++;
    if (ans !== 64'hFF) begin
      fails++; $display("FAIL drop_ans got=%h exp=ff", ans);
    end
  endtask

  task automatic test_random();
    int sel;
    for (int n = 0; n < 300; n++) begin
      a = {$urandom, $urandom};
      sel = $urandom_range(0, 3);
      b = (sel == 0) ? ~a : (sel == 1) ? {$urandom, $urandom} | 64'h8000_0000_0000_0000
        : {$urandom, $urandom};
      if (sel == 1) a[63] = 1'b1;
      in_valid = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 19) == 0);
      #1;
      tests++;
      if (ans !== ref_and(a, b)) begin
        fails++; $display("FAIL rnd_ans n=%0d got=%h exp=%h", n, ans, ref_and(a, b));
      end
      tick();
      tests++;
      if (ans_q !== m_q || out_valid !== m_v) begin
        fails++;
        $display("FAIL rnd_reg n=%0d got=%h/%b exp=%h/%b", n, ans_q, out_valid, m_q, m_v);
      end
`ifdef AND64_FLAGS_EN
      tests++;
      if ({zf, sf, of} !== {m_zf, m_sf, 1'b0}) begin
        fails++;
        $display("FAIL rnd_flags n=%0d got=%b exp=%b", n, {zf, sf, of}, {m_zf, m_sf, 1'b0});
      end
`endif
    end
    rst = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0;
    m_q = '0; m_v = 1'b0; m_zf = 1'b0; m_sf = 1'b0;
    test_reset();
    test_all_ones();
    test_back_to_back();
    test_patterns();
    test_reset_priority();
    test_valid_drop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
